// File: rtl/cnn_pkg.sv
// Shared constants and the frame-controller state type for the CNN front end.
package cnn_pkg;

    localparam int IMG_W       = 28;
    localparam int IMG_H       = 28;
    localparam int PIX_W       = 8;
    localparam int NUM_CLASSES = 10;
    localparam int CLASS_W     = 4;
    localparam int ROW_W       = $clog2(IMG_H);
    localparam int COL_W       = $clog2(IMG_W);

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_ARM,
        FS_RUN,
        FS_RESULT
    } frame_state_t;

endpackage

// File: rtl/raster_counter.sv
// Row/column raster position for an incoming frame; wraps column into row, flags the final pixel.
module raster_counter
    import cnn_pkg::*;
#(
    parameter int W = IMG_W,
    parameter int H = IMG_H
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 advance,
    output logic [$clog2(H)-1:0] row,
    output logic [$clog2(W)-1:0] col,
    output logic                 is_last
);

    localparam int RW = $clog2(H);
    localparam int CW = $clog2(W);
    localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(W - 1);

    assign is_last = (row == ROW_MAX) && (col == COL_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnn_frame_ctrl.sv
// Frame controller: buffers one raster image, launches the CNN core, returns its class on a handshake.
module cnn_frame_ctrl
    import cnn_pkg::*;
#(
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic signed [PIX_W-1:0]   s_pixel,
    input  logic                      s_valid,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic signed [PIX_W-1:0]   image [0:IMG_H-1][0:IMG_W-1],
    output logic                      cnn_start,
    input  logic                      cnn_done,
    input  logic [CLASS_W-1:0]        cnn_class,
    output logic [CLASS_W-1:0]        result_class,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic                      frame_err,
    output logic                      timeout_err
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC - 1);

    frame_state_t     state;
    logic [TMR_W-1:0] timer;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             is_last;
    logic             accept;
    logic             frame_end;

    assign s_ready   = (state == FS_IDLE);
    assign accept    = s_valid && s_ready;
    // Either a proper end of frame or a framing error restarts the raster position.
    assign frame_end = accept && (s_last || is_last);

    raster_counter #(.W(IMG_W), .H(IMG_H)) u_raster (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (frame_end),
        .advance (accept),
        .row     (row),
        .col     (col),
        .is_last (is_last)
    );

    // NOTE: the frame buffer is plain storage with no reset; every pixel is written before launch.
    always_ff @(posedge clk) begin
        if (accept) begin
            image[row][col] <= s_pixel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= FS_IDLE;
            timer        <= '0;
            cnn_start    <= 1'b0;
            result_valid <= 1'b0;
            result_class <= '0;
            frame_err    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                FS_IDLE: begin
                    timer <= '0;
                    if (frame_end) begin
                        if (s_last && is_last) state     <= FS_ARM;
                        else                   frame_err <= 1'b1;
                    end
                end
                FS_ARM: begin
                    if (!cnn_done) begin
                        state     <= FS_RUN;
                        timer     <= '0;
                        cnn_start <= 1'b1;
                    end else if (timer == TMR_MAX) begin
                        state       <= FS_IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                FS_RUN: begin
                    // A done seen on the timeout cycle still delivers its result.
                    if (cnn_done) begin
                        state        <= FS_RESULT;
                        cnn_start    <= 1'b0;
                        result_class <= cnn_class;
                        result_valid <= 1'b1;
                    end else if (timer == TMR_MAX) begin
                        state       <= FS_IDLE;
                        cnn_start   <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                FS_RESULT: begin
                    timer <= '0;
                    if (result_ready) begin
                        state        <= FS_IDLE;
                        result_valid <= 1'b0;
                    end
                end
                default: state <= FS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_frame_ctrl.sv
// Directed bench for cnn_frame_ctrl: framing table plus hand sequences for launch, reset and timeout.
module tb_cnn_frame_ctrl;
    import cnn_pkg::*;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic signed [PIX_W-1:0] s_pixel = '0;
    logic                    s_valid = 1'b0;
    logic                    s_last = 1'b0;
    logic                    s_ready;
    logic signed [PIX_W-1:0] image [0:IMG_H-1][0:IMG_W-1];
    logic                    cnn_start;
    logic                    cnn_done = 1'b0;
    logic [CLASS_W-1:0]      cnn_class = '0;
    logic [CLASS_W-1:0]      result_class;
    logic                    result_valid;
    logic                    result_ready = 1'b0;
    logic                    frame_err;
    logic                    timeout_err;

    // Second instance with a short timeout, driven by its own stream.
    logic signed [PIX_W-1:0] t_pixel = '0;
    logic                    t_valid = 1'b0;
    logic                    t_last = 1'b0;
    logic                    t_ready;
    logic signed [PIX_W-1:0] t_image [0:IMG_H-1][0:IMG_W-1];
    logic                    t_start;
    logic [CLASS_W-1:0]      t_class;
    logic                    t_rvalid;
    logic                    t_ferr;
    logic                    t_terr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cnn_frame_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .s_pixel(s_pixel), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .image(image), .cnn_start(cnn_start), .cnn_done(cnn_done), .cnn_class(cnn_class),
        .result_class(result_class), .result_valid(result_valid), .result_ready(result_ready),
        .frame_err(frame_err), .timeout_err(timeout_err)
    );

    cnn_frame_ctrl #(.TIMEOUT_CYC(64)) dut_to (
        .clk(clk), .reset_n(reset_n),
        .s_pixel(t_pixel), .s_valid(t_valid), .s_last(t_last), .s_ready(t_ready),
        .image(t_image), .cnn_start(t_start), .cnn_done(1'b0), .cnn_class(4'd5),
        .result_class(t_class), .result_valid(t_rvalid), .result_ready(1'b1),
        .frame_err(t_ferr), .timeout_err(t_terr)
    );

    typedef struct {
        string      name;
        int         n_pix;
        int         last_idx;
        int         max_gap;
        logic [7:0] key;
        logic       exp_err;
        logic [3:0] cls;
    } frame_vec_t;

    frame_vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [7:0] pix_val(input int idx, input logic [7:0] key);
        logic [7:0] v;
        v = idx[7:0] ^ key;
        return v;
    endfunction

    // Called at a negedge with s_ready high; returns at the negedge after the accepting edge.
    task automatic push(input logic signed [7:0] p, input logic l);
        s_pixel = p;
        s_valid = 1'b1;
        s_last  = l;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_pixel = 8'($urandom);
    endtask

    task automatic send_frame(input int n, input int last_idx, input logic [7:0] key, input int max_gap);
        for (int i = 0; i < n; i++) begin
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            push(pix_val(i, key), i == last_idx);
        end
    endtask

    task automatic check_frame(input string name, input logic [7:0] key);
        int bad;
        bad = 0;
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                if (image[r][c] !== pix_val(r * IMG_W + c, key)) bad++;
        check(name, bad, 0);
    endtask

    // Called at the first negedge with cnn_start high; done rises after lat cycles of RUN.
    task automatic run_core(input string name, input int lat, input logic [3:0] cls);
        repeat (lat - 1) @(negedge clk);
        check({name, "_start_held"}, cnn_start, 1);
        cnn_done  = 1'b1;
        cnn_class = cls;
        @(negedge clk);
        cnn_done  = 1'b0;
        cnn_class = '0;
        check({name, "_rvalid"}, result_valid, 1);
        check({name, "_rclass"}, result_class, cls);
        check({name, "_start_off"}, cnn_start, 0);
    endtask

    task automatic take_result(input string name);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check({name, "_rvalid_drop"}, result_valid, 0);
        check({name, "_idle_ready"}, s_ready, 1);
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        checks++;
        failures++;
        $display("FAIL watchdog: got no finish within 200000 cycles expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int n;

        vecs[0] = '{"early_last_500", 501, 500, 0, 8'h00, 1'b1, 4'd0};
        vecs[1] = '{"good_after_500", 784, 783, 1, 8'h5A, 1'b0, 4'd9};
        vecs[2] = '{"no_last_783",    784, -1,  0, 8'h00, 1'b1, 4'd0};
        vecs[3] = '{"last_first_pix", 1,   0,   0, 8'h00, 1'b1, 4'd0};
        vecs[4] = '{"last_end_row0",  28,  27,  0, 8'h00, 1'b1, 4'd0};
        vecs[5] = '{"good_gappy",     784, 783, 2, 8'h33, 1'b0, 4'd2};

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_cnn_start", cnn_start, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_class", result_class, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_timeout_err", timeout_err, 0);

        // First frame: launch latency, buffer contents, held result.
        send_frame(784, 783, 8'h00, 0);
        check("a_start_arm", cnn_start, 0);
        check("a_ready_arm", s_ready, 0);
        @(negedge clk);
        check("a_start_lat2", cnn_start, 1);
        check("a_img_1_0", image[1][0], 28);
        check("a_img_27_27", image[27][27], 783 % 256);
        check_frame("a_pixels", 8'h00);
        run_core("a", 100, 4'd7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("a_hold_valid", result_valid, 1);
            check("a_hold_class", result_class, 7);
        end
        take_result("a");

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].n_pix, vecs[v].last_idx, vecs[v].key, vecs[v].max_gap);
            check({vecs[v].name, "_ferr"}, frame_err, vecs[v].exp_err);
            if (vecs[v].exp_err) begin
                check({vecs[v].name, "_ready"}, s_ready, 1);
                @(negedge clk);
                check({vecs[v].name, "_ferr_pulse"}, frame_err, 0);
                check({vecs[v].name, "_no_start"}, cnn_start, 0);
            end else begin
                check({vecs[v].name, "_ready_arm"}, s_ready, 0);
                @(negedge clk);
                check({vecs[v].name, "_start"}, cnn_start, 1);
                check_frame({vecs[v].name, "_pixels"}, vecs[v].key);
                run_core(vecs[v].name, 5, vecs[v].cls);
                take_result(vecs[v].name);
            end
        end

        // ARM holds off while the core still reports done, then reset lands mid-RUN.
        cnn_done = 1'b1;
        send_frame(784, 783, 8'h11, 0);
        for (int i = 0; i < 4; i++) begin
            check("arm_wait_start", cnn_start, 0);
            check("arm_wait_ready", s_ready, 0);
            @(negedge clk);
        end
        cnn_done = 1'b0;
        @(negedge clk);
        check("arm_release_start", cnn_start, 1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_run_start", cnn_start, 0);
        check("rst_run_rvalid", result_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_run_ready", s_ready, 1);

        // Partial frame discarded by reset; the next gappy frame must land aligned.
        send_frame(40, -1, 8'h77, 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_frame(784, 783, 8'hC3, 3);
        @(negedge clk);
        check("post_rst_start", cnn_start, 1);
        check_frame("post_rst_pixels", 8'hC3);
        run_core("post_rst", 12, 4'd12);
        take_result("post_rst");

        // Timeout instance: done never arrives.
        for (int i = 0; i < 784; i++) begin
            t_pixel = pix_val(i, 8'h00);
            t_valid = 1'b1;
            t_last  = (i == 783);
            @(negedge clk);
        end
        t_valid = 1'b0;
        t_last  = 1'b0;
        n = 0;
        while (!t_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("to_start_seen", t_start, 1);
        n = 0;
        while (!t_terr && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("to_cycles", n, 64);
        check("to_start_off", t_start, 0);
        check("to_idle", t_ready, 1);
        check("to_no_result", t_rvalid, 0);
        @(negedge clk);
        check("to_pulse", t_terr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
